// File: rtl/arp_pkg.sv
// arp_pkg: shared ARP opcodes, broadcast MAC and resolver state encoding
package arp_pkg;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;
  localparam logic [47:0] ARP_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_BCAST_RESP,
    S_QUERY,
    S_WAIT_QUERY,
    S_SEND_REQ,
    S_WAIT_REPLY,
    S_RESPOND
  } arp_state_t;
endpackage

// File: rtl/arp_resolver_if.sv
// arp_resolver_if: request/response, cache and ARP frame handshakes of the resolver
interface arp_resolver_if;
  logic        arp_request_valid;
  logic        arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid;
  logic        arp_response_ready;
  logic        arp_response_error;
  logic [47:0] arp_response_mac;
  logic        cache_query_request_valid;
  logic        cache_query_request_ready;
  logic [31:0] cache_query_request_ip;
  logic        cache_query_response_valid;
  logic        cache_query_response_ready;
  logic        cache_query_response_error;
  logic [47:0] cache_query_response_mac;
  logic        cache_write_request_valid;
  logic        cache_write_request_ready;
  logic [31:0] cache_write_request_ip;
  logic [47:0] cache_write_request_mac;
  logic        arp_tx_valid;
  logic        arp_tx_ready;
  logic [15:0] arp_tx_oper;
  logic [31:0] arp_tx_tpa;
  logic        arp_rx_valid;
  logic        arp_rx_ready;
  logic [15:0] arp_rx_oper;
  logic [47:0] arp_rx_sha;
  logic [31:0] arp_rx_spa;
  logic [31:0] arp_rx_tpa;
  modport master (
    input  arp_request_valid, arp_request_ip, arp_response_ready,
           cache_query_request_ready, cache_query_response_valid,
           cache_query_response_error, cache_query_response_mac,
           cache_write_request_ready, arp_tx_ready,
           arp_rx_valid, arp_rx_oper, arp_rx_sha, arp_rx_spa, arp_rx_tpa,
    output arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
           cache_query_request_valid, cache_query_request_ip, cache_query_response_ready,
           cache_write_request_valid, cache_write_request_ip, cache_write_request_mac,
           arp_tx_valid, arp_tx_oper, arp_tx_tpa, arp_rx_ready
  );
  modport slave (
    output arp_request_valid, arp_request_ip, arp_response_ready,
           cache_query_request_ready, cache_query_response_valid,
           cache_query_response_error, cache_query_response_mac,
           cache_write_request_ready, arp_tx_ready,
           arp_rx_valid, arp_rx_oper, arp_rx_sha, arp_rx_spa, arp_rx_tpa,
    input  arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
           cache_query_request_valid, cache_query_request_ip, cache_query_response_ready,
           cache_write_request_valid, cache_write_request_ip, cache_write_request_mac,
           arp_tx_valid, arp_tx_oper, arp_tx_tpa, arp_rx_ready
  );
endinterface

// File: rtl/arp_retry_timer.sv
// arp_retry_timer: reply timeout counter, loaded on each request handshake
module arp_retry_timer #(
  parameter int RETRY_INTERVAL = 125000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expired
);
  localparam int W = $clog2(RETRY_INTERVAL);
  localparam logic [W-1:0] LOAD = W'(RETRY_INTERVAL - 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= LOAD;
    else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - W'(1);
  end
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/arp_resolver.sv
// arp_resolver: next-hop IPv4 to MAC resolution with cache lookup, ARP retries
// and learning of bindings from received ARP frames
module arp_resolver
  import arp_pkg::*;
#(
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 125000000
) (
  input  logic                 clk,
  input  logic                 rst,
  arp_resolver_if.master       bus,
  input  logic [31:0]          i_local_ip,
  input  logic [31:0]          i_gateway_ip,
  input  logic [31:0]          i_subnet_mask,
  input  logic                 i_clear_cache
);
  localparam int TW = $clog2(RETRY_COUNT + 1);
  arp_state_t r_state, w_next;
  logic [31:0] r_target, w_target;
  logic [47:0] r_resp_mac, w_resp_mac;
  logic        r_resp_err, w_resp_err, w_resp_load;
  logic [TW-1:0] r_tries;
  logic        r_abort;
  logic        r_wb_full;
  logic [31:0] r_wb_ip;
  logic [47:0] r_wb_mac;
  logic        w_req_fire, w_qresp_fire, w_tx_fire, w_rx_fire, w_wr_fire;
  logic        w_bcast, w_match, w_learn, w_expired, w_fail;
  assign w_req_fire   = bus.arp_request_valid && bus.arp_request_ready;
  assign w_qresp_fire = bus.cache_query_response_valid && bus.cache_query_response_ready;
  assign w_tx_fire    = bus.arp_tx_valid && bus.arp_tx_ready;
  assign w_rx_fire    = bus.arp_rx_valid && bus.arp_rx_ready;
  assign w_wr_fire    = bus.cache_write_request_valid && bus.cache_write_request_ready;
  assign w_target = ((bus.arp_request_ip ^ i_local_ip) & i_subnet_mask) == '0 ? bus.arp_request_ip : i_gateway_ip;
  assign w_bcast  = bus.arp_request_ip == '1 || (bus.arp_request_ip | i_subnet_mask) == '1;
  assign w_match  = r_state == S_WAIT_REPLY && w_rx_fire && bus.arp_rx_oper == ARP_OPER_REPLY &&
                    bus.arp_rx_spa == r_target && bus.arp_rx_tpa == i_local_ip;
  assign w_learn  = w_rx_fire && (bus.arp_rx_oper == ARP_OPER_REQUEST || bus.arp_rx_oper == ARP_OPER_REPLY) &&
                    bus.arp_rx_tpa == i_local_ip && bus.arp_rx_spa != '0;
  // an aborted request still lets an in-flight tx beat finish before erroring
  assign w_fail = (i_clear_cache && (r_state inside {S_QUERY, S_WAIT_QUERY, S_WAIT_REPLY})) ||
                  (i_clear_cache && r_state == S_IDLE && w_req_fire) ||
                  (r_state == S_SEND_REQ && w_tx_fire && (i_clear_cache || r_abort)) ||
                  (r_state == S_WAIT_REPLY && !w_match && w_expired && r_tries >= TW'(RETRY_COUNT));
  arp_retry_timer #(.RETRY_INTERVAL(RETRY_INTERVAL)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tx_fire),
    .i_dec     (r_state == S_WAIT_REPLY),
    .o_expired (w_expired)
  );
  always_comb begin
    w_next      = r_state;
    w_resp_load = 1'b0;
    w_resp_mac  = '0;
    w_resp_err  = 1'b0;
    case (r_state)
      S_IDLE: if (w_req_fire) begin
        w_next      = w_bcast ? S_BCAST_RESP : S_QUERY;
        w_resp_load = w_bcast;
        w_resp_mac  = ARP_BCAST_MAC;
      end
      S_QUERY: if (bus.cache_query_request_ready) w_next = S_WAIT_QUERY;
      S_WAIT_QUERY: if (w_qresp_fire) begin
        w_next      = bus.cache_query_response_error ? S_SEND_REQ : S_RESPOND;
        w_resp_load = !bus.cache_query_response_error;
        w_resp_mac  = bus.cache_query_response_mac;
      end
      S_SEND_REQ: if (w_tx_fire) w_next = S_WAIT_REPLY;
      S_WAIT_REPLY: if (w_match) begin
        w_next      = S_RESPOND;
        w_resp_load = 1'b1;
        w_resp_mac  = bus.arp_rx_sha;
      end else if (w_expired) w_next = S_SEND_REQ;
      S_RESPOND, S_BCAST_RESP: if (bus.arp_response_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_fail) begin
      w_next      = S_RESPOND;
      w_resp_load = 1'b1;
      w_resp_mac  = '0;
      w_resp_err  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_target   <= '0;
      r_resp_mac <= '0;
      r_resp_err <= 1'b0;
      r_tries    <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_req_fire) r_target <= w_target;
      if (w_resp_load) begin
        r_resp_mac <= w_resp_mac;
        r_resp_err <= w_resp_err;
      end
      r_tries <= (w_qresp_fire && bus.cache_query_response_error) ? '0 : w_tx_fire ? r_tries + TW'(1) : r_tries;
      r_abort <= r_state == S_SEND_REQ && !w_tx_fire && (r_abort || i_clear_cache);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || i_clear_cache) r_wb_full <= 1'b0;
    else if (w_wr_fire) r_wb_full <= 1'b0;
    else if (w_learn) begin
      r_wb_full <= 1'b1;
      r_wb_ip   <= bus.arp_rx_spa;
      r_wb_mac  <= bus.arp_rx_sha;
    end
  end
  assign bus.arp_request_ready          = r_state == S_IDLE && !rst;
  assign bus.arp_response_valid         = r_state == S_RESPOND || r_state == S_BCAST_RESP;
  assign bus.arp_response_error         = r_resp_err;
  assign bus.arp_response_mac           = r_resp_mac;
  assign bus.cache_query_request_valid  = r_state == S_QUERY;
  assign bus.cache_query_request_ip     = r_target;
  assign bus.cache_query_response_ready = r_state == S_WAIT_QUERY;
  assign bus.cache_write_request_valid  = r_wb_full;
  assign bus.cache_write_request_ip     = r_wb_ip;
  assign bus.cache_write_request_mac    = r_wb_mac;
  assign bus.arp_tx_valid               = r_state == S_SEND_REQ;
  assign bus.arp_tx_oper                = ARP_OPER_REQUEST;
  assign bus.arp_tx_tpa                 = r_target;
  assign bus.arp_rx_ready               = !r_wb_full;
endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: directed checks of broadcast, cache hit/miss, retries, learning,
// clear_cache and reset behaviour with RETRY_INTERVAL=16, RETRY_COUNT=3
module tb_arp_resolver;
  import arp_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] local_ip = 32'hC0A8_0180;
  logic [31:0] gateway_ip = 32'hC0A8_0101;
  logic [31:0] subnet_mask = 32'hFFFF_FF00;
  logic clear_cache = 1'b0;
  int n_assert = 0, n_fail = 0;
  int tx_hs = 0, q_hs = 0, wr_hs = 0, resp_hs = 0;
  int tx0, q0, wr0, r0, gap;
  always #5 clk = ~clk;
  arp_resolver_if bus ();
  arp_resolver #(.RETRY_COUNT(3), .RETRY_INTERVAL(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .i_local_ip    (local_ip),
    .i_gateway_ip  (gateway_ip),
    .i_subnet_mask (subnet_mask),
    .i_clear_cache (clear_cache)
  );
  always @(posedge clk) begin
    if (bus.arp_tx_valid && bus.arp_tx_ready) tx_hs <= tx_hs + 1;
    if (bus.cache_query_request_valid && bus.cache_query_request_ready) q_hs <= q_hs + 1;
    if (bus.cache_write_request_valid && bus.cache_write_request_ready) wr_hs <= wr_hs + 1;
    if (bus.arp_response_valid && bus.arp_response_ready) resp_hs <= resp_hs + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick; @(posedge clk); #1; endtask
  task automatic mid; @(negedge clk); endtask
  task automatic rx(input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    bus.arp_rx_valid = 1'b1;
    bus.arp_rx_oper  = oper;
    bus.arp_rx_sha   = sha;
    bus.arp_rx_spa   = spa;
    bus.arp_rx_tpa   = tpa;
  endtask
  task automatic request(input logic [31:0] ip);
    tick; bus.arp_request_valid = 1'b1; bus.arp_request_ip = ip;
    tick; bus.arp_request_valid = 1'b0;
  endtask
  task automatic miss_to_send;
    tick; bus.cache_query_response_valid = 1'b1; bus.cache_query_response_error = 1'b1;
    tick; bus.cache_query_response_valid = 1'b0; bus.cache_query_response_error = 1'b0;
  endtask
  initial begin
    bus.arp_request_valid = 0; bus.arp_request_ip = 0; bus.arp_response_ready = 1;
    bus.cache_query_request_ready = 1; bus.cache_query_response_valid = 0;
    bus.cache_query_response_error = 0; bus.cache_query_response_mac = 0;
    bus.cache_write_request_ready = 1; bus.arp_tx_ready = 1;
    bus.arp_rx_valid = 0; bus.arp_rx_oper = 0; bus.arp_rx_sha = 0; bus.arp_rx_spa = 0; bus.arp_rx_tpa = 0;
    mid;
    chk("rst_req_ready", bus.arp_request_ready, 0);
    chk("rst_resp_valid", bus.arp_response_valid, 0);
    chk("rst_tx_valid", bus.arp_tx_valid, 0);
    chk("rst_query_valid", bus.cache_query_request_valid, 0);
    chk("rst_write_valid", bus.cache_write_request_valid, 0);
    chk("rst_rx_ready", bus.arp_rx_ready, 1);
    chk("rst_resp_err", bus.arp_response_error, 0);
    chk("rst_resp_mac", bus.arp_response_mac, 0);
    tick; rst = 1'b0;
    mid; chk("idle_req_ready", bus.arp_request_ready, 1);
    // broadcast, with response held for two cycles
    tx0 = tx_hs; q0 = q_hs;
    bus.arp_response_ready = 1'b0;
    request(32'hC0A8_01FF);
    mid;
    chk("bcast_valid", bus.arp_response_valid, 1);
    chk("bcast_mac", bus.arp_response_mac, 48'hFFFF_FFFF_FFFF);
    chk("bcast_err", bus.arp_response_error, 0);
    chk("bcast_req_ready", bus.arp_request_ready, 0);
    tick; mid; chk("bcast_hold", bus.arp_response_valid, 1);
    tick; bus.arp_response_ready = 1'b1;
    tick; mid;
    chk("bcast_done", bus.arp_response_valid, 0);
    chk("bcast_idle", bus.arp_request_ready, 1);
    chk("bcast_no_query", q_hs - q0, 0);
    chk("bcast_no_tx", tx_hs - tx0, 0);
    // cache hit
    request(32'hC0A8_010A);
    mid;
    chk("hit_query_valid", bus.cache_query_request_valid, 1);
    chk("hit_query_ip", bus.cache_query_request_ip, 32'hC0A8_010A);
    tick; bus.cache_query_response_valid = 1'b1; bus.cache_query_response_mac = 48'h0200_0000_000A;
    mid; chk("hit_qresp_ready", bus.cache_query_response_ready, 1);
    tick; bus.cache_query_response_valid = 1'b0;
    mid;
    chk("hit_resp_valid", bus.arp_response_valid, 1);
    chk("hit_resp_mac", bus.arp_response_mac, 48'h0200_0000_000A);
    chk("hit_resp_err", bus.arp_response_error, 0);
    tick; mid;
    chk("hit_done", bus.arp_response_valid, 0);
    chk("hit_no_tx", tx_hs - tx0, 0);
    // off-subnet miss, reply and learning with write port stalled
    wr0 = wr_hs;
    bus.cache_write_request_ready = 1'b0;
    request(32'h0A00_0005);
    mid; chk("miss_query_ip", bus.cache_query_request_ip, 32'hC0A8_0101);
    miss_to_send;
    mid;
    chk("miss_tx_valid", bus.arp_tx_valid, 1);
    chk("miss_tx_tpa", bus.arp_tx_tpa, 32'hC0A8_0101);
    chk("miss_tx_oper", bus.arp_tx_oper, 1);
    tick; rx(ARP_OPER_REPLY, 48'h0200_0000_0001, 32'hC0A8_0101, 32'hC0A8_0180);
    mid; chk("miss_rx_ready", bus.arp_rx_ready, 1);
    tick; bus.arp_rx_valid = 1'b0;
    mid;
    chk("reply_resp_valid", bus.arp_response_valid, 1);
    chk("reply_resp_mac", bus.arp_response_mac, 48'h0200_0000_0001);
    chk("reply_resp_err", bus.arp_response_error, 0);
    chk("learn_wr_valid", bus.cache_write_request_valid, 1);
    chk("learn_wr_ip", bus.cache_write_request_ip, 32'hC0A8_0101);
    chk("learn_wr_mac", bus.cache_write_request_mac, 48'h0200_0000_0001);
    chk("learn_rx_full", bus.arp_rx_ready, 0);
    tick; mid; chk("learn_rx_still_full", bus.arp_rx_ready, 0);
    tick; bus.cache_write_request_ready = 1'b1;
    tick; mid;
    chk("learn_wr_done", bus.cache_write_request_valid, 0);
    chk("learn_rx_free", bus.arp_rx_ready, 1);
    chk("learn_wr_count", wr_hs - wr0, 1);
    // frames not for us and zero spa are ignored; oper 1 to us is learned
    tick; rx(ARP_OPER_REPLY, 48'h0200_0000_0099, 32'hC0A8_0105, 32'hC0A8_0199);
    tick; rx(ARP_OPER_REQUEST, 48'h0200_0000_0098, 32'h0, 32'hC0A8_0180);
    tick; bus.arp_rx_valid = 1'b0;
    mid;
    chk("ignore_wr_valid", bus.cache_write_request_valid, 0);
    chk("ignore_rx_ready", bus.arp_rx_ready, 1);
    bus.cache_write_request_ready = 1'b0;
    tick; rx(ARP_OPER_REQUEST, 48'h0200_0000_000B, 32'hC0A8_010B, 32'hC0A8_0180);
    tick; bus.arp_rx_valid = 1'b0;
    mid;
    chk("req_learn_valid", bus.cache_write_request_valid, 1);
    chk("req_learn_ip", bus.cache_write_request_ip, 32'hC0A8_010B);
    chk("req_learn_mac", bus.cache_write_request_mac, 48'h0200_0000_000B);
    tick; tick; mid; chk("req_learn_full", bus.arp_rx_ready, 0);
    tick; bus.cache_write_request_ready = 1'b1;
    tick; mid;
    chk("req_learn_free", bus.arp_rx_ready, 1);
    chk("req_learn_done", bus.cache_write_request_valid, 0);
    // three retries spaced RETRY_INTERVAL, reply during tx handshake ignored
    tx0 = tx_hs;
    request(32'h0A00_0005);
    miss_to_send;
    mid;
    chk("retry_tx0_valid", bus.arp_tx_valid, 1);
    rx(ARP_OPER_REPLY, 48'h0200_0000_0077, 32'hC0A8_0101, 32'hC0A8_0180);
    tick; bus.arp_rx_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      gap = 0;
      while (gap < 100) begin
        mid;
        if (bus.arp_tx_valid || bus.arp_response_valid) break;
        gap++;
      end
      chk("retry_gap", gap, 16);
      if (b < 2) begin
        chk("retry_tx_valid", bus.arp_tx_valid, 1);
        chk("retry_tx_tpa", bus.arp_tx_tpa, 32'hC0A8_0101);
        tick;
      end
    end
    chk("retry_err_valid", bus.arp_response_valid, 1);
    chk("retry_err", bus.arp_response_error, 1);
    chk("retry_err_mac", bus.arp_response_mac, 0);
    chk("retry_tx_count", tx_hs - tx0, 3);
    tick; mid; chk("retry_idle", bus.arp_request_ready, 1);
    // reply in the same cycle as expiry wins
    request(32'h0A00_0005);
    miss_to_send;
    tick;
    repeat (15) tick;
    rx(ARP_OPER_REPLY, 48'h0200_0000_0055, 32'hC0A8_0101, 32'hC0A8_0180);
    tick; bus.arp_rx_valid = 1'b0;
    mid;
    chk("race_resp_valid", bus.arp_response_valid, 1);
    chk("race_resp_mac", bus.arp_response_mac, 48'h0200_0000_0055);
    chk("race_resp_err", bus.arp_response_error, 0);
    chk("race_tx_valid", bus.arp_tx_valid, 0);
    tick;
    // clear_cache in WAIT_REPLY
    request(32'h0A00_0005);
    miss_to_send;
    tick; tick; clear_cache = 1'b1;
    tick; clear_cache = 1'b0;
    mid;
    chk("clear_resp_valid", bus.arp_response_valid, 1);
    chk("clear_resp_err", bus.arp_response_error, 1);
    chk("clear_resp_mac", bus.arp_response_mac, 0);
    tick; mid; chk("clear_idle", bus.arp_request_ready, 1);
    // clear_cache concurrent with request handshake
    q0 = q_hs;
    tick; bus.arp_request_valid = 1'b1; bus.arp_request_ip = 32'hC0A8_0110; clear_cache = 1'b1;
    tick; bus.arp_request_valid = 1'b0; clear_cache = 1'b0;
    mid;
    chk("clrreq_resp_valid", bus.arp_response_valid, 1);
    chk("clrreq_resp_err", bus.arp_response_error, 1);
    chk("clrreq_no_query", bus.cache_query_request_valid, 0);
    tick; mid; chk("clrreq_no_query_hs", q_hs - q0, 0);
    // reset mid WAIT_REPLY drops the request silently
    request(32'h0A00_0005);
    miss_to_send;
    tick; tick; rst = 1'b1;
    tick; rst = 1'b0;
    r0 = resp_hs; tx0 = tx_hs;
    mid;
    chk("rstmid_resp_valid", bus.arp_response_valid, 0);
    chk("rstmid_idle", bus.arp_request_ready, 1);
    chk("rstmid_tx_valid", bus.arp_tx_valid, 0);
    repeat (20) tick;
    chk("rstmid_no_resp", resp_hs - r0, 0);
    chk("rstmid_no_tx", tx_hs - tx0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/arp_resolver.md
# arp_resolver

Resolves next-hop IPv4 addresses to MAC addresses for the IP transmit path. Each upstream request is classified as broadcast, on-subnet or off-subnet. Broadcasts are answered directly; all others are looked up in the ARP cache. On a cache miss, the block issues ARP requests with timed retries. It also learns MAC bindings from received ARP frames and writes them into the cache, acting as the initiator on the cache's query and write ports.

## Interface
- RETRY_COUNT, 4: total ARP request transmissions per miss before error (≥1)
- RETRY_INTERVAL, 125000000: cycles from each request handshake to timeout (≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- arp_request_valid / arp_request_ready  in/out  1/1  upstream resolve request handshake
- arp_request_ip  in  32  IP to resolve
- arp_response_valid / arp_response_ready  out/in  1/1  result handshake
- arp_response_error  out  1  1 = unresolved after retries
- arp_response_mac  out  48  resolved MAC
- cache_query_request_valid / cache_query_request_ready  out/in  1/1  cache lookup
- cache_query_request_ip  out  32  lookup key
- cache_query_response_valid / cache_query_response_ready  in/out  1/1
- cache_query_response_error  in  1  miss
- cache_query_response_mac  in  48
- cache_write_request_valid / cache_write_request_ready  out/in  1/1
- cache_write_request_ip / cache_write_request_mac  out  32/48  learned binding
- arp_tx_valid / arp_tx_ready  out/in  1/1  ARP frame header to framer
- arp_tx_oper  out  16  always 1 (request)
- arp_tx_tpa  out  32  target IP; SHA/SPA taken by framer from local config, THA = 0
- arp_rx_valid / arp_rx_ready  in/out  1/1  parsed ARP header from receiver
- arp_rx_oper  in  16
- arp_rx_sha / arp_rx_spa / arp_rx_tpa  in  48/32/32
- local_ip, gateway_ip, subnet_mask  in  32 each  static configuration
- clear_cache  in  1  pulse; aborts pending request with error

## Operation
- Target IP t: t = request IP when (ip & mask) == (local_ip & mask), else gateway_ip.
- Broadcast: request IP == 32'hFFFFFFFF or (ip | mask) == 32'hFFFFFFFF; respond MAC 48'hFFFFFFFFFFFF, error 0, no cache access.
- FSM states: IDLE → (accept) BCAST_RESP | QUERY.
- QUERY: assert cache_query_request_valid with t until handshake → WAIT_QUERY.
- WAIT_QUERY: cache_query_response_ready=1; hit → RESPOND (mac); miss → SEND_REQ with tries=0.
- SEND_REQ: arp_tx_valid until handshake; tries+1; load timer → WAIT_REPLY.
- WAIT_REPLY: a matching rx frame (oper 2 with spa == t and tpa == local_ip) → RESPOND with rx sha. On timer expiry: SEND_REQ if tries < RETRY_COUNT, else RESPOND with error=1, mac=0.
- RESPOND/BCAST_RESP: hold response until handshake → IDLE.
- arp_request_ready = 1 only in IDLE.
- Learning, independent of FSM: rx oper 1 or 2 with tpa == local_ip and spa ≠ 0 is loaded into a 1-entry write buffer. The buffer drives cache_write_request_* until handshake. arp_rx_ready = !buffer_full. Frames not addressed to us are consumed and ignored.
- clear_cache: if FSM is in QUERY/WAIT_QUERY/SEND_REQ/WAIT_REPLY → RESPOND error=1. A held ARP tx beat is not retracted if already asserted; it completes first. The write buffer is emptied.

## Timing
- Reset: all valid outputs 0, arp_request_ready 0 in the reset cycle then 1 (IDLE), arp_rx_ready 1, response error/mac 0, tries 0, timer 0, buffer empty.
- Broadcast: response valid the cycle after request handshake.
- Cache hit: response valid one cycle after cache response handshake.
- Timer: loaded with RETRY_INTERVAL-1 on the tx handshake cycle; decrements every cycle in WAIT_REPLY; expiry on reaching 0. Total wait exactly RETRY_INTERVAL cycles.
- A matching reply and timer expiry in the same cycle: the reply wins.
- A matching reply in the same cycle as the tx handshake is ignored; only WAIT_REPLY matches.
- clear_cache concurrent with a request handshake: the request is accepted, then immediately errors.
- Reset mid-operation: FSM returns to IDLE; pending request dropped with no response.
- tries width: $clog2(RETRY_COUNT+1); timer width: $clog2(RETRY_INTERVAL).

## Structure
- Shared package arp_pkg: ARP_OPER_REQUEST=16'd1, ARP_OPER_REPLY=16'd2, ARP_BCAST_MAC, resolver state encoding.
- One sub-module, arp_retry_timer: load/decrement/expire counter parameterised by RETRY_INTERVAL.
- Write buffer and FSM live in the top module.

## Test plan
- Config local 192.168.1.128/24, gw 192.168.1.1: request 192.168.1.255 → response mac FF:FF:FF:FF:FF:FF, error 0, no cache or tx activity.
- Request 192.168.1.10, cache hit mac 02:00:00:00:00:0A → response that mac, error 0, no tx.
- Request 10.0.0.5 → cache query ip 192.168.1.1; on miss, tx tpa 192.168.1.1; reply spa 192.168.1.1 sha 02:..:01 → response 02:..:01 and cache write (192.168.1.1, 02:..:01).
- RETRY_INTERVAL=16, RETRY_COUNT=3, no reply → 3 tx beats spaced 16 cycles, then error=1 exactly 16 cycles after the third handshake.
- Rx request addressed to us while cache_write_request_ready=0 → buffer full, arp_rx_ready=0 until the write handshake completes.
- clear_cache during WAIT_REPLY → error response next cycle; reset mid-WAIT_REPLY → no response, FSM in IDLE.
